envelope_bank: RTL
==================

ENVELOPE_BANK -- requirements
Module: envelope_bank

Interface
REQ-001 Parameter CHANNELS, default 3, number of independent envelope channels (1..8).
REQ-002 Parameter PERIOD_BITS, default 16, envelope period width.
REQ-003 Parameter ENVELOPE_BITS, default 4, envelope level width (4 = AY, 5 = YM style).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 tick  in  1  step enable (prescaled strobe); period counters advance only when high.
REQ-007 wr_en  in  1  write strobe, one cycle.
REQ-008 wr_sel  in  1  0 = write period, 1 = write shape.
REQ-009 wr_channel  in  max(1,$clog2(CHANNELS))  target channel.
REQ-010 wr_data  in  PERIOD_BITS  period value, or shape in bits [3:0] = {continue, attack, alternate, hold}.
REQ-011 out  out  CHANNELS*ENVELOPE_BITS  packed levels, channel n at [n*ENVELOPE_BITS +: ENVELOPE_BITS].
REQ-012 held  out  CHANNELS  per-channel flag, 1 = envelope finished and holding.

Function
REQ-013 Per channel state: period, shape, period_cnt (PERIOD_BITS), step_cnt (ENVELOPE_BITS), invert, held; MAX = all-ones ENVELOPE_BITS.
REQ-014 Effective period Peff = max(period,1); period 0 behaves as 1.
REQ-015 On tick: if period_cnt >= Peff-1, period_cnt <= 0 and a step occurs; else period_cnt increments; ">=" covers period lowered below current count (step on next tick, no wrap-around).
REQ-016 Step with held=1: no change.
REQ-017 Step with step_cnt < MAX: step_cnt increments.
REQ-018 Step with step_cnt == MAX and hold_eff=1: held <= 1, step_cnt unchanged.
REQ-019 Step with step_cnt == MAX and hold_eff=0: step_cnt <= 0; invert toggles if alternate=1.
REQ-020 hold_eff = hold OR NOT continue.
REQ-021 Hold level: 0 if continue=0; else MAX if attack XOR alternate, else 0.
REQ-022 out level = held ? hold level : (invert ? MAX-step_cnt : step_cnt); combinational from state, no added latency.
REQ-023 Period write (wr_sel=0): loads period only; no restart of step_cnt, invert, held, period_cnt.
REQ-024 Shape write (wr_sel=1): loads shape, period_cnt <= 0, step_cnt <= 0, held <= 0, invert <= NOT attack (retrigger).
REQ-025 Write and tick in same cycle on same channel: write wins, that channel ignores the tick; other channels step normally.
REQ-026 Writes with wr_channel >= CHANNELS are ignored.
REQ-027 After a shape write with Peff=P and tick held high, first step on the P-th tick; a full ramp takes (MAX+1)*P ticks.
REQ-028 Channels are fully independent; one write port, one channel per cycle.

Reset
REQ-029 reset high asynchronously forces every channel: period 0, shape 0000, period_cnt 0, step_cnt 0, invert 1, held 1.
REQ-030 During and after reset: out all 0, held all 1; reset mid-ramp discards progress immediately, without waiting for clk.
REQ-031 First write after reset deassertion is accepted on the next rising edge.

Verification (CHANNELS=3, ENVELOPE_BITS=4, tick=1)
REQ-032 Reset pulse mid-operation -> out=0 and held=3'b111 immediately and in all cycles while reset is high.
REQ-033 ch0 period 2, shape 1100 -> level 0,0,1,1,...,15,15 then 0 (wrap at tick 32), held[0]=0 throughout.
REQ-034 ch1 period 1, shape 1010 -> level 15 down to 0, 0 again, up to 15, 15, down; invert toggles every 16 steps.
REQ-035 ch2 period 1, shape 0000 -> 15..0 over 16 ticks, held[2]=1 on 16th step, level 0 forever; shape 1011 -> same ramp, then held level 15.
REQ-036 ch0 running, period write 100 -> 3 at step_cnt 7 with period_cnt 50 -> no restart, step on next tick; shape write same cycle as tick -> step_cnt 0, invert = NOT attack, tick ignored on ch0 only.
REQ-037 Write to wr_channel=3 -> no state change on any channel.

Source files
------------

// File: rtl/envelope_bank.sv
// ---------------------------------------------------------------------------
// envelope_bank
//
// Purpose:
//   A bank of independent AY/YM-style envelope generators. Each channel holds
//   a period and a 4-bit shape {continue, attack, alternate, hold}. On every
//   prescaled tick the channel's period counter advances. When the counter
//   reaches the effective period, the envelope takes one step. Depending on
//   the shape, the level then ramps, wraps, alternates direction or freezes
//   at a hold level.
//
// Ports:
//   clk         in   single clock, all state updates on the rising edge
//   reset       in   asynchronous active-high reset
//   tick        in   step enable strobe; period counters advance only when high
//   wr_en       in   one-cycle write strobe
//   wr_sel      in   0 = write period, 1 = write shape (retrigger)
//   wr_channel  in   target channel; out-of-range channels are ignored
//   wr_data     in   period value, or shape in bits [3:0]
//   out         out  packed levels, channel n at [n*ENVELOPE_BITS +: ENVELOPE_BITS]
//   held        out  per-channel flag, 1 = envelope finished and holding
// ---------------------------------------------------------------------------
module envelope_bank #(
  parameter int CHANNELS      = 3,
  parameter int PERIOD_BITS   = 16,
  parameter int ENVELOPE_BITS = 4,
  localparam int CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tick,
  input  logic                              wr_en,
  input  logic                              wr_sel,
  input  logic [CH_BITS-1:0]                wr_channel,
  input  logic [PERIOD_BITS-1:0]            wr_data,
  output logic [CHANNELS*ENVELOPE_BITS-1:0] out,
  output logic [CHANNELS-1:0]               held
);

  localparam logic [ENVELOPE_BITS-1:0] MAX_LEVEL = '1;

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : gChan

    logic [PERIOD_BITS-1:0]   r_period;
    logic [3:0]               r_shape;
    logic [PERIOD_BITS-1:0]   r_periodCnt;
    logic [ENVELOPE_BITS-1:0] r_stepCnt;
    logic                     r_invert;
    logic                     r_held;

    logic                     w_write;
    logic                     w_continue;
    logic                     w_attack;
    logic                     w_alternate;
    logic                     w_hold;
    logic                     w_holdEff;
    logic [PERIOD_BITS-1:0]   w_peffMinus1;
    logic                     w_stepNow;
    logic                     w_atMax;
    logic [ENVELOPE_BITS-1:0] w_holdLevel;
    logic [ENVELOPE_BITS-1:0] w_rampLevel;

    // Decode the write port for this channel. Channel indices that do not
    // exist never match any generated channel, so such writes fall away.
    // The shape nibble is split into named fields to keep the step rules
    // below readable.
    always_comb begin
      w_write     = wr_en && (wr_channel == CH_BITS'(g));
      w_continue  = r_shape[3];
      w_attack    = r_shape[2];
      w_alternate = r_shape[1];
      w_hold      = r_shape[0];
      // A one-shot envelope (continue = 0) always stops at the end of its
      // first ramp, whatever the hold bit says.
      w_holdEff   = w_hold || !w_continue;
    end

    // Period terminal-count detection. A period of zero behaves like one.
    // The compare is ">=" rather than "==" so that lowering the period
    // below the running count causes a step on the very next tick instead
    // of a long wrap through the full counter range.
    always_comb begin
      w_peffMinus1 = '0;
      if (r_period != '0) begin
        w_peffMinus1 = r_period - PERIOD_BITS'(1);
      end
      w_stepNow = (r_periodCnt >= w_peffMinus1);
      w_atMax   = (r_stepCnt == MAX_LEVEL);
    end

    // Per-channel state update. Reset parks the channel in the finished,
    // holding state with a zero level. A write always beats a tick on the
    // same channel. A period write only swaps the period and leaves the
    // running envelope untouched. A shape write restarts the envelope from
    // step zero, with its direction chosen by the attack bit. Without a
    // write, a tick either advances the period counter or produces a step.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_period    <= '0;
        r_shape     <= 4'b0000;
        r_periodCnt <= '0;
        r_stepCnt   <= '0;
        r_invert    <= 1'b1;
        r_held      <= 1'b1;
      end else if (w_write) begin
        if (!wr_sel) begin
          r_period <= wr_data;
        end else begin
          r_shape     <= wr_data[3:0];
          r_periodCnt <= '0;
          r_stepCnt   <= '0;
          r_held      <= 1'b0;
          r_invert    <= !wr_data[2];
        end
      end else if (tick) begin
        if (w_stepNow) begin
          r_periodCnt <= '0;
          if (!r_held) begin
            if (!w_atMax) begin
              r_stepCnt <= r_stepCnt + ENVELOPE_BITS'(1);
            end else if (w_holdEff) begin
              r_held <= 1'b1;
            end else begin
              r_stepCnt <= '0;
              if (w_alternate) begin
                r_invert <= !r_invert;
              end
            end
          end
        end else begin
          r_periodCnt <= r_periodCnt + PERIOD_BITS'(1);
        end
      end
    end

    // Output level, purely combinational from state. While holding, a
    // continuing envelope freezes at the top only when attack and alternate
    // disagree. Every other finished envelope rests at zero. While running,
    // the invert flag mirrors the step count to make a falling ramp.
    always_comb begin
      w_holdLevel = '0;
      if (w_continue && (w_attack ^ w_alternate)) begin
        w_holdLevel = MAX_LEVEL;
      end
      w_rampLevel = r_invert ? (MAX_LEVEL - r_stepCnt) : r_stepCnt;
      out[g*ENVELOPE_BITS +: ENVELOPE_BITS] = r_held ? w_holdLevel : w_rampLevel;
      held[g] = r_held;
    end

  end

endmodule
